// File: rtl/serial_adder_pkg.sv
// Shared types and helpers for the digit-serial adder.
package serial_adder_pkg;

  typedef enum logic {
    S_IDLE,
    S_RUN
  } state_t;

  // Counter width for n states, never narrower than one bit.
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/serial_adder_if.sv
// Start/busy/done handshake plus operand and result buses of the serial adder.
interface serial_adder_if #(
  parameter int unsigned WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] Sum;
  logic             Cout;
  logic             ovf;

  modport master (
    output start, A, B, Cin,
    input  busy, done, Sum, Cout, ovf
  );

  modport slave (
    input  start, A, B, Cin,
    output busy, done, Sum, Cout, ovf
  );
endinterface

// File: rtl/serial_adder_digit_adder.sv
// DIGIT-bit combinational ripple-carry cell, reused every cycle by serial_adder.
module digit_adder #(
  parameter int unsigned DIGIT = 1
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             ci,
  output logic [DIGIT-1:0] s,
  output logic             co,
  output logic             c_msb
);

  // Ripple through full-adder cells; c_msb keeps the carry entering the top bit.
  always_comb begin
    logic carry;
    carry = ci;
    c_msb = ci;
    s     = '0;
    for (int unsigned i = 0; i < DIGIT; i++) begin
      c_msb = carry;
      s[i]  = a[i] ^ b[i] ^ carry;
      carry = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
    end
    co = carry;
  end

endmodule

// File: rtl/serial_adder.sv
// Multi-cycle adder: Sum = A + B + Cin over WIDTH bits, DIGIT bits per clock,
// LSB digit first, with a start/busy/done handshake and signed-overflow flag.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DIGIT = 1
) (
  input  logic         clk,
  input  logic         rst,
  serial_adder_if.slave bus
);

  if (WIDTH < 1) begin : g_bad_width
    $error("serial_adder: WIDTH must be at least 1");
  end
  if (DIGIT < 1 || DIGIT > WIDTH) begin : g_bad_digit
    $error("serial_adder: DIGIT must be in 1..WIDTH");
  end else if ((WIDTH % DIGIT) != 0) begin : g_bad_ratio
    $error("serial_adder: WIDTH must be a multiple of DIGIT");
  end

  localparam int unsigned N  = WIDTH / DIGIT;
  localparam int unsigned CW = cnt_w(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  state_t           state;
  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] opb;
  logic [WIDTH-1:0] res;
  logic [WIDTH-1:0] res_next;
  logic             carry;
  logic [CW-1:0]    cnt;

  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;
  logic             ovf_q;

  logic [DIGIT-1:0] dsum;
  logic             dco;
  logic             dmsb;

  digit_adder #(.DIGIT(DIGIT)) u_digit (
    .a     (opa[DIGIT-1:0]),
    .b     (opb[DIGIT-1:0]),
    .ci    (carry),
    .s     (dsum),
    .co    (dco),
    .c_msb (dmsb)
  );

  // Result register shifts right, the new digit entering at the MSB end; this
  // form also covers DIGIT == WIDTH where nothing of the old value survives.
  always_comb begin
    res_next = (res >> DIGIT) | (WIDTH'(dsum) << (WIDTH - DIGIT));
  end

  // Control FSM, datapath registers and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      opa    <= '0;
      opb    <= '0;
      res    <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      sum_q  <= '0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            opa    <= bus.A;
            opb    <= bus.B;
            carry  <= bus.Cin;
            cnt    <= '0;
            busy_q <= 1'b1;
            state  <= S_RUN;
          end
        end
        S_RUN: begin
          opa   <= opa >> DIGIT;
          opb   <= opb >> DIGIT;
          res   <= res_next;
          carry <= dco;
          cnt   <= cnt + CW'(1);
          if (cnt == LAST) begin
            sum_q  <= res_next;
            cout_q <= dco;
            ovf_q  <= dmsb ^ dco;
            done_q <= 1'b1;
            busy_q <= 1'b0;
            state  <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.Sum  = sum_q;
  assign bus.Cout = cout_q;
  assign bus.ovf  = ovf_q;

endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder across four WIDTH/DIGIT configurations.
module tb_serial_adder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // w index: 0 = 8x1, 1 = 4x2, 2 = 8x2, 3 = 8x8
  serial_adder_if #(.WIDTH(8)) b81 ();
  serial_adder_if #(.WIDTH(4)) b42 ();
  serial_adder_if #(.WIDTH(8)) b82 ();
  serial_adder_if #(.WIDTH(8)) b88 ();

  serial_adder #(.WIDTH(8), .DIGIT(1)) u81 (.clk(clk), .rst(rst), .bus(b81));
  serial_adder #(.WIDTH(4), .DIGIT(2)) u42 (.clk(clk), .rst(rst), .bus(b42));
  serial_adder #(.WIDTH(8), .DIGIT(2)) u82 (.clk(clk), .rst(rst), .bus(b82));
  serial_adder #(.WIDTH(8), .DIGIT(8)) u88 (.clk(clk), .rst(rst), .bus(b88));

  int checks = 0;
  int errors = 0;

  typedef struct {
    int         w;
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [7:0] sum;
    logic       cout;
    logic       ovf;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int n_of(input int w);
    case (w)
      0:       return 8;
      1:       return 2;
      2:       return 4;
      default: return 1;
    endcase
  endfunction

  task automatic drive(input int w, input logic s, input logic [7:0] a,
                       input logic [7:0] b, input logic c);
    case (w)
      0: begin b81.start = s; b81.A = a;      b81.B = b;      b81.Cin = c; end
      1: begin b42.start = s; b42.A = a[3:0]; b42.B = b[3:0]; b42.Cin = c; end
      2: begin b82.start = s; b82.A = a;      b82.B = b;      b82.Cin = c; end
      default: begin b88.start = s; b88.A = a; b88.B = b; b88.Cin = c; end
    endcase
  endtask

  function automatic logic g_done(input int w);
    case (w)
      0: return b81.done;  1: return b42.done;  2: return b82.done;
      default: return b88.done;
    endcase
  endfunction

  function automatic logic g_busy(input int w);
    case (w)
      0: return b81.busy;  1: return b42.busy;  2: return b82.busy;
      default: return b88.busy;
    endcase
  endfunction

  function automatic logic [7:0] g_sum(input int w);
    case (w)
      0: return b81.Sum;   1: return {4'h0, b42.Sum};  2: return b82.Sum;
      default: return b88.Sum;
    endcase
  endfunction

  function automatic logic g_cout(input int w);
    case (w)
      0: return b81.Cout;  1: return b42.Cout;  2: return b82.Cout;
      default: return b88.Cout;
    endcase
  endfunction

  function automatic logic g_ovf(input int w);
    case (w)
      0: return b81.ovf;   1: return b42.ovf;   2: return b82.ovf;
      default: return b88.ovf;
    endcase
  endfunction

  // Start one operation, scramble the inputs after acceptance, wait (bounded)
  // for done. lat counts edges after the accepting edge; bc counts busy samples.
  task automatic run_op(input int w, input logic [7:0] a, input logic [7:0] b,
                        input logic c, output int lat, output int bc);
    drive(w, 1'b1, a, b, c);
    tick();
    drive(w, 1'b0, ~a, ~b, ~c);
    lat = 0;
    bc  = 0;
    while (!g_done(w) && lat < 40) begin
      if (g_busy(w)) bc++;
      tick();
      lat++;
    end
  endtask

  vec_t vecs[$];

  initial begin
    int lat, bc, ndone, done_at;

    vecs = '{
      '{0, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0},
      '{0, 8'h7F, 8'h00, 1'b1, 8'h80, 1'b0, 1'b1},
      '{0, 8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1},
      '{0, 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0},
      '{0, 8'h40, 8'h40, 1'b0, 8'h80, 1'b0, 1'b1},
      '{0, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0},
      '{0, 8'h3C, 8'h42, 1'b0, 8'h7E, 1'b0, 1'b0},
      '{3, 8'hC8, 8'h64, 1'b1, 8'h2D, 1'b1, 1'b0},
      '{3, 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1},
      '{2, 8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0},
      '{2, 8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1, 1'b0}
    };

    for (int w = 0; w < 4; w++) drive(w, 1'b0, 8'h00, 8'h00, 1'b0);
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;

    // Reset state of every configuration.
    for (int w = 0; w < 4; w++) begin
      chk($sformatf("rst_busy_w%0d", w), 32'(g_busy(w)), 32'd0);
      chk($sformatf("rst_done_w%0d", w), 32'(g_done(w)), 32'd0);
      chk($sformatf("rst_sum_w%0d", w),  32'(g_sum(w)),  32'd0);
      chk($sformatf("rst_cout_w%0d", w), 32'(g_cout(w)), 32'd0);
      chk($sformatf("rst_ovf_w%0d", w),  32'(g_ovf(w)),  32'd0);
    end

    // Table-driven single operations.
    foreach (vecs[i]) begin
      run_op(vecs[i].w, vecs[i].a, vecs[i].b, vecs[i].cin, lat, bc);
      chk($sformatf("v%0d_latency", i), 32'(lat), 32'(n_of(vecs[i].w)));
      chk($sformatf("v%0d_busy_cycles", i), 32'(bc), 32'(n_of(vecs[i].w)));
      chk($sformatf("v%0d_busy_at_done", i), 32'(g_busy(vecs[i].w)), 32'd0);
      chk($sformatf("v%0d_sum", i),  32'(g_sum(vecs[i].w)),  32'(vecs[i].sum));
      chk($sformatf("v%0d_cout", i), 32'(g_cout(vecs[i].w)), 32'(vecs[i].cout));
      chk($sformatf("v%0d_ovf", i),  32'(g_ovf(vecs[i].w)),  32'(vecs[i].ovf));
      tick();
      chk($sformatf("v%0d_done_pulse", i), 32'(g_done(vecs[i].w)), 32'd0);
    end

    // Ignored start on 8x1: second start lands while busy (3 edges in).
    drive(0, 1'b1, 8'h0F, 8'h01, 1'b0);
    tick();
    drive(0, 1'b0, 8'h00, 8'h00, 1'b0);
    tick();
    tick();
    drive(0, 1'b1, 8'hAA, 8'h55, 1'b0);
    tick();
    drive(0, 1'b0, 8'h00, 8'h00, 1'b0);
    chk("ign_busy_mid", 32'(g_busy(0)), 32'd1);
    chk("ign_sum_held", 32'(g_sum(0)), 32'h7E);
    ndone   = 0;
    done_at = 0;
    for (int e = 4; e <= 14; e++) begin
      tick();
      if (g_done(0)) begin
        ndone++;
        if (done_at == 0) begin
          done_at = e;
          chk("ign_sum",  32'(g_sum(0)),  32'h10);
          chk("ign_cout", 32'(g_cout(0)), 32'd0);
          chk("ign_ovf",  32'(g_ovf(0)),  32'd0);
        end
      end
    end
    chk("ign_done_edge", 32'(done_at), 32'd8);
    chk("ign_done_count", 32'(ndone), 32'd1);

    // Reset mid-operation on 8x2, starting from non-zero held outputs.
    run_op(2, 8'h90, 8'h90, 1'b0, lat, bc);
    chk("rm_pre_sum",  32'(g_sum(2)),  32'h20);
    chk("rm_pre_cout", 32'(g_cout(2)), 32'd1);
    chk("rm_pre_ovf",  32'(g_ovf(2)),  32'd1);
    tick();
    drive(2, 1'b1, 8'h11, 8'h22, 1'b0);
    tick();
    drive(2, 1'b0, 8'h00, 8'h00, 1'b0);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rm_busy", 32'(g_busy(2)), 32'd0);
    chk("rm_done", 32'(g_done(2)), 32'd0);
    chk("rm_sum",  32'(g_sum(2)),  32'd0);
    chk("rm_cout", 32'(g_cout(2)), 32'd0);
    chk("rm_ovf",  32'(g_ovf(2)),  32'd0);
    ndone = 0;
    for (int e = 0; e < 6; e++) begin
      tick();
      if (g_done(2)) ndone++;
    end
    chk("rm_no_done", 32'(ndone), 32'd0);
    run_op(2, 8'h12, 8'h34, 1'b0, lat, bc);
    chk("rm_next_latency", 32'(lat), 32'd4);
    chk("rm_next_sum", 32'(g_sum(2)), 32'h46);
    tick();

    // Exhaustive 4x2, back-to-back with start raised in each done cycle.
    drive(1, 1'b1, 8'h00, 8'h00, 1'b0);
    tick();
    for (int i = 0; i < 512; i++) begin
      logic [3:0] ea, eb;
      logic       ec;
      int         full, sgn;
      ea = 4'(i >> 5);
      eb = 4'(i >> 1);
      ec = 1'(i);
      drive(1, 1'b0, 8'h00, 8'h00, 1'b0);
      lat = 0;
      while (!g_done(1) && lat < 20) begin
        tick();
        lat++;
      end
      full = int'(ea) + int'(eb) + int'(ec);
      sgn  = int'($signed(ea)) + int'($signed(eb)) + int'(ec);
      chk($sformatf("ex%0d_latency", i), 32'(lat), 32'd2);
      chk($sformatf("ex%0d_sum", i), 32'(g_sum(1)), 32'(full & 15));
      chk($sformatf("ex%0d_cout", i), 32'(g_cout(1)), 32'((full >> 4) & 1));
      chk($sformatf("ex%0d_ovf", i), 32'(g_ovf(1)), 32'((sgn > 7 || sgn < -8) ? 1 : 0));
      if (i < 511) begin
        drive(1, 1'b1, 8'((i + 1) >> 5), 8'((i + 1) >> 1), 1'((i + 1)));
        tick();
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_adder.md
# serial_adder

Parametrised, multi-cycle adder that computes `Sum = A + B + Cin` over `WIDTH` bits by processing `DIGIT` bits per clock, LSB digit first. A single `DIGIT`-wide ripple cell is reused every cycle, with carry held in a flip-flop between cycles. It is the sequential, area-reduced successor to the team's single-bit combinational full adder. It sits behind a start/busy/done handshake and adds a signed-overflow flag.

## Interface
- `WIDTH`, default 8: operand/result width in bits; must be ≥ 1.
- `DIGIT`, default 1: bits processed per cycle; `WIDTH % DIGIT == 0` is required (elaboration error otherwise).
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  request; sampled only when `busy == 0`.
- `A`  in  WIDTH  operand A; sampled with accepted `start`.
- `B`  in  WIDTH  operand B; sampled with accepted `start`.
- `Cin`  in  1  carry-in; sampled with accepted `start`.
- `busy`  out  1  high while an operation is in progress.
- `done`  out  1  one-cycle pulse; results valid from this cycle.
- `Sum`  out  WIDTH  result bits.
- `Cout`  out  1  unsigned carry out of the MSB.
- `ovf`  out  1  two's-complement overflow: carry into MSB XOR carry out of MSB.

## Operation
- `N = WIDTH/DIGIT` cycles per operation.
- **Reset:** `busy`, `done`, `Sum`, `Cout` and `ovf` are all 0. State is S_IDLE; the internal carry, digit counter and operand registers are cleared.
- **S_IDLE:** on `start=1`, do the following, then go to S_RUN:
  - latch A and B into shift registers;
  - load `Cin` into the carry flip-flop;
  - set the counter to 0.
- **S_RUN, each cycle:**
  - `digit_adder` adds the low `DIGIT` bits of both shift registers and the carry flip-flop.
  - The digit sum shifts into the result register from the MSB side.
  - The operands shift right by `DIGIT`.
  - The carry flip-flop takes the digit carry-out.
  - The counter increments.
- **Last digit** (counter == N-1):
  - Capture `Cout` = digit carry-out.
  - Capture `ovf` = digit MSB carry-in XOR digit carry-out.
  - Pulse `done`, clear `busy` and return to S_IDLE.
- **Result hold:** `Sum`, `Cout` and `ovf` hold their values until the next accepted operation's final cycle. They do not change while a new operation runs; the result register is internal, and `Sum` is updated only at completion.
- **`start` while `busy=1`:** ignored. Operands are not re-sampled and there is no error flag.
- **`start` in the `done` cycle:** accepted, because `busy=0`. Back-to-back throughput is one result per N cycles.
- **`rst` mid-operation:** aborts the operation. All outputs return to reset values on that edge, and no `done` is produced.
- **Width rule:** all arithmetic is modulo 2^WIDTH. `Cout` is bit WIDTH of the full sum, and there is no sign extension.
- **`DIGIT == WIDTH`:** N=1. `done` occurs one cycle after `start`.

## Timing
- `start` is accepted at edge k.
- `busy=1` from edge k until edge k+N.
- At edge k+N:
  - `busy` drops to 0;
  - `done` rises to 1 for exactly one cycle;
  - `Sum`, `Cout` and `ovf` update.
- Latency, start edge to done edge: exactly N cycles.
- Inputs `A`, `B` and `Cin` need to be stable only at the accepting edge.
- All outputs are registered, with no combinational input-to-output paths.

## Structure
- Package `serial_adder_pkg`:
  - state typedef `enum {S_IDLE, S_RUN}`;
  - function `cnt_w(n)` returning `$clog2` with a minimum of 1, for the counter width.
- Sub-module `digit_adder #(DIGIT)`:
  - inputs: `a[DIGIT]`, `b[DIGIT]`, `ci`;
  - outputs: `s[DIGIT]`, `co`, `c_msb` (carry into the top bit);
  - purely combinational ripple of full-adder cells.
- Top module: FSM, counter, shift registers and output registers.

## Test plan
- **Unsigned wrap:** WIDTH=8, DIGIT=1, A=8'hFF, B=8'h01, Cin=0 → Sum=8'h00, Cout=1, ovf=0. `done` exactly 8 cycles after `start`; `busy` high for those 8 cycles.
- **Signed overflow:** WIDTH=8, DIGIT=1, A=8'h7F, B=8'h00, Cin=1 → Sum=8'h80, Cout=0, ovf=1. Then A=8'h80, B=8'h80, Cin=0 → Sum=8'h00, Cout=1, ovf=1.
- **Exhaustive:** WIDTH=4, DIGIT=2, all 512 combinations of A, B and Cin run back-to-back, with `start` asserted in each `done` cycle.
  - {Cout,Sum} must equal A+B+Cin.
  - ovf must match the signed reference.
  - Latency must be 2 every time.
- **Ignored start:** WIDTH=8, DIGIT=1, A=8'h0F, B=8'h01. Then `start` with A=8'hAA, B=8'h55 at cycle 3 while busy.
  - Result Sum=8'h10, Cout=0, `done` at cycle 8.
  - Only one `done` pulse is produced.
- **Reset mid-op:** WIDTH=8, DIGIT=2, `rst` at cycle 2 of an operation.
  - On that edge: all outputs become 0 and no `done` is produced.
  - A following operation A=8'h12, B=8'h34 → Sum=8'h46 after 4 cycles.
- **Single-cycle config:** WIDTH=8, DIGIT=8, A=8'hC8, B=8'h64, Cin=1 → Sum=8'h2D, Cout=1, ovf=0, `done` one cycle after `start`.
